octal_frame_serializer: RTL and testbench
=========================================

Name: octal_frame_serializer

Overview:
- Sits directly downstream of the per-channel bit-order correction stage in the high-speed octal synchronous capture path.
- Latches one synchronous frame of 8 corrected 14-bit ADC samples on a sample strobe.
- Serializes each frame as a tagged 16-bit word stream (1 header + 8 channel words) over a valid/ready interface to the host-side FIFO.
- Double-buffers one pending frame and counts frames dropped on overflow.

Parameters:
- DATA_W, 14, sample width per channel (must be ≤ 16)
- NUM_CH, 8, channels per frame (must be a power of 2, ≥ 2)
- HDR_TAG, 8'hA5, upper byte of every header word
- CNT_W, 16, width of the saturating drop counter

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- samples  in  NUM_CH*DATA_W  packed frame; channel k occupies bits [k*DATA_W +: DATA_W]
- sample_valid  in  1  one-cycle strobe; samples valid this cycle
- out_data  out  16  serialized word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- busy  out  1  high when pending buffer or active frame is occupied
- drop_cnt  out  CNT_W  number of frames dropped since reset; saturates at all-ones
- seq  out  8  sequence number of the next accepted frame

Behaviour:
- Reset (synchronous, active-high) clears all of the following:
  - state = IDLE; pending_full = 0
  - out_valid = 0; out_data = 0; busy = 0
  - drop_cnt = 0; seq = 0; channel index = 0
  - Reset mid-frame abandons the frame with no partial completion. out_valid is 0 the cycle after reset is sampled.
- Capture:
  - On sample_valid, if pending_full == 0 (or pending is being transferred to active this same cycle), copy samples into the pending buffer and set pending_full.
  - Otherwise discard the frame and increment drop_cnt (saturating). seq is unchanged.
- Handshake:
  - A word transfers on a rising edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_valid are held stable.
  - out_valid never deasserts without a transfer, except on reset.
  - out_data and out_valid are registered outputs.
- State machine:
  - IDLE: out_valid = 0. If pending_full, then active <= pending, pending_full <= 0, out_data <= {HDR_TAG, seq}, out_valid <= 1, seq <= seq+1 (wraps 255→0), go to HDR.
  - HDR: on transfer, out_data <= word(active ch 0), idx <= 1, go to CH.
  - CH: on transfer with idx < NUM_CH, out_data <= word(active ch idx), idx++.
  - CH, on transfer of the last channel word:
    - if pending_full: perform the IDLE load action in the same cycle and go to HDR (back-to-back, no bubble);
    - else: out_valid <= 0, go to IDLE.
- Channel word: {(16-DATA_W) zero bits, sample}.
- Header sequence value: the seq value before the increment.
- Latency: sample_valid sampled at edge N with IDLE and pending empty -> header visible with out_valid=1 after edge N+1.
- Throughput: 9 words per frame. Sustained drop-free rate requires sample_valid spacing ≥ 9 cycles with out_ready held high.
- Simultaneous sample_valid with pending→active transfer: the new frame is captured and not dropped.
- busy = pending_full || state != IDLE.

Optional Feature:
- Macro: OCTAL_SER_SIGN_EXT_EN.
- Defined: channel words sign-extend the sample, replicating bit DATA_W-1 into bits 15:DATA_W (two's-complement ADC output).
- Undefined: channel words zero-extend. All other behaviour is identical.

Test Plan:
- Single frame, out_ready=1: samples ch k = 14'h0100+k, one sample_valid -> 9 consecutive words: 16'hA500, then 16'h0100..16'h0107; out_valid drops after the last word; seq = 1.
- Backpressure: out_ready toggled 1,0,0,1,... during the frame -> out_data stable while stalled; same 9-word sequence; no duplicated or lost words.
- Overflow: out_ready=0, three sample_valid strobes -> first frame held in HDR, second in pending, third dropped (drop_cnt = 1). Then out_ready=1 -> 18 words, headers 16'hA500 then 16'hA501, back-to-back with no idle cycle.
- Sign extension: ch0 = 14'h2001 -> word 16'h2001 without the macro; 16'hE001 with OCTAL_SER_SIGN_EXT_EN.
- Reset mid-frame: assert reset after 3 channel words -> out_valid = 0, drop_cnt = 0, seq = 0 next cycle. A new frame afterwards starts with header 16'hA500.
- Wrap/saturation: 256 accepted frames -> header byte wraps 8'hFF→8'h00. With CNT_W overridden to 2, 5 forced drops -> drop_cnt stays 2'b11.

Source files
------------

// File: rtl/octal_frame_serializer_if.sv
`default_nettype none
//==============================================================================
// Module : octal_frame_serializer_if
// Brief  : 16-bit valid/ready word stream from the serializer to the host FIFO.
// Rev    : 1.0  initial release
//==============================================================================
interface octal_frame_serializer_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/octal_frame_serializer.sv
`default_nettype none
//==============================================================================
// Module : octal_frame_serializer
// Brief  : Latches NUM_CH-channel ADC frames and streams each one as a tagged
//          header plus NUM_CH 16-bit words; macro OCTAL_SER_SIGN_EXT_EN selects
//          sign extension of channel words instead of zero extension.
// Rev    : 1.0  initial release
//==============================================================================
module octal_frame_serializer #(
    parameter int         DATA_W  = 14,
    parameter int         NUM_CH  = 8,
    parameter logic [7:0] HDR_TAG = 8'hA5,
    parameter int         CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] samples,
    input  logic                     sample_valid,
    octal_frame_serializer_if.master out_if,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [7:0]               seq
);
    localparam int                 c_SEL_W    = $clog2(NUM_CH);
    localparam int                 c_IDX_W    = c_SEL_W + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_CH   = 2'd2;

    logic [1:0]               r_state,     w_state_nx;
    logic [c_IDX_W-1:0]       r_idx,       w_idx_nx;
    logic [15:0]              r_out_data,  w_out_data_nx;
    logic                     r_out_valid, w_out_valid_nx;
    logic [NUM_CH*DATA_W-1:0] r_pending;
    logic                     r_pending_full;
    logic [DATA_W-1:0]        r_active [NUM_CH];
    logic [CNT_W-1:0]         r_drop_cnt;
    logic [7:0]               r_seq;
    logic                     w_xfer;
    logic                     w_load;
    logic                     w_accept;

    function automatic logic [15:0] f_chan_word(input logic [DATA_W-1:0] s);
`ifdef OCTAL_SER_SIGN_EXT_EN
        return 16'($signed(s));
`else
        return 16'(s);
`endif
    endfunction

    always_comb begin
        w_xfer         = r_out_valid && out_if.out_ready;
        w_load         = 1'b0;
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_out_data_nx  = r_out_data;
        w_out_valid_nx = r_out_valid;

        case (r_state)
            c_ST_IDLE: begin
                if (r_pending_full) begin
                    w_load = 1'b1;
                end
            end
            c_ST_HDR: begin
                if (w_xfer) begin
                    w_out_data_nx = f_chan_word(r_active[0]);
                    w_idx_nx      = c_IDX_W'(1);
                    w_state_nx    = c_ST_CH;
                end
            end
            c_ST_CH: begin
                if (w_xfer) begin
                    if (r_idx < c_LAST_IDX) begin
                        w_out_data_nx = f_chan_word(r_active[r_idx[c_SEL_W-1:0]]);
                        w_idx_nx      = r_idx + c_IDX_W'(1);
                    end else if (r_pending_full) begin
                        // last word leaves while the next frame waits: chain without a bubble
                        w_load = 1'b1;
                    end else begin
                        w_out_valid_nx = 1'b0;
                        w_state_nx     = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_out_valid_nx = 1'b0;
                w_state_nx     = c_ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_out_data_nx  = {HDR_TAG, r_seq};
            w_out_valid_nx = 1'b1;
            w_state_nx     = c_ST_HDR;
        end

        // the pending slot is reusable in the same cycle it moves to active
        w_accept = sample_valid && (!r_pending_full || w_load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_idx          <= '0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_pending_full <= 1'b0;
            r_drop_cnt     <= '0;
            r_seq          <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_out_data  <= w_out_data_nx;
            r_out_valid <= w_out_valid_nx;
            if (w_load) begin
                r_seq <= r_seq + 8'd1;
            end
            if (w_accept) begin
                r_pending_full <= 1'b1;
            end else if (w_load) begin
                r_pending_full <= 1'b0;
            end
            if (sample_valid && !w_accept && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pending <= samples;
        end
        if (w_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_active[k] <= r_pending[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_if.out_data  = r_out_data;
    assign out_if.out_valid = r_out_valid;
    assign busy             = r_pending_full || (r_state != c_ST_IDLE);
    assign drop_cnt         = r_drop_cnt;
    assign seq              = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_octal_frame_serializer.sv
`default_nettype none
//==============================================================================
// Module : tb_octal_frame_serializer
// Brief  : Randomized and directed bench with a queue-based frame model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_octal_frame_serializer;
    localparam int DATA_W = 14;
    localparam int NUM_CH = 8;
    localparam int FW     = DATA_W * NUM_CH;

    logic          clk = 1'b0;
    logic          reset;
    logic [FW-1:0] samples;
    logic          sample_valid;
    logic          busy, busy2;
    logic [15:0]   drop_cnt;
    logic [1:0]    drop_cnt2;
    logic [7:0]    seq, seq2;

    octal_frame_serializer_if if1 ();
    octal_frame_serializer_if if2 ();
    assign if2.out_ready = 1'b0;

    octal_frame_serializer dut (
        .clk(clk), .reset(reset), .samples(samples), .sample_valid(sample_valid),
        .out_if(if1), .busy(busy), .drop_cnt(drop_cnt), .seq(seq)
    );

    // saturation instance: never drained, so every extra frame is a drop
    octal_frame_serializer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .samples(samples), .sample_valid(sample_valid),
        .out_if(if2), .busy(busy2), .drop_cnt(drop_cnt2), .seq(seq2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // reference model: words still owed for the current frame, the queued words, one pending frame
    logic [15:0]   exp_q[$];
    int            m_left;
    logic [FW-1:0] m_pend;
    bit            m_pend_full;
    logic [7:0]    m_seq;
    logic [15:0]   m_drop;
    bit            m_xfer, m_promote, m_accept;
    logic [15:0]   got_q[$];
    int            got_t[$];
    int            cyc = 0;

    int rdy_mode  = 0;
    bit rdy_const = 1'b1;
    int pat_i     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] chan_word(input logic [DATA_W-1:0] s);
`ifdef OCTAL_SER_SIGN_EXT_EN
        return {{(16-DATA_W){s[DATA_W-1]}}, s};
`else
        return {{(16-DATA_W){1'b0}}, s};
`endif
    endfunction

    function automatic logic [FW-1:0] ramp(input logic [DATA_W-1:0] base);
        logic [FW-1:0] v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*DATA_W +: DATA_W] = base + DATA_W'(k);
        return v;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [127:0] t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            got_q.delete();
            got_t.delete();
            m_left      = 0;
            m_pend_full = 1'b0;
            m_seq       = 8'd0;
            m_drop      = 16'd0;
        end else begin
            if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
                got_q.push_back(if1.out_data);
                got_t.push_back(cyc);
            end
            m_xfer    = (m_left > 0) && (if1.out_ready === 1'b1);
            m_promote = m_pend_full && (m_left == 0 || (m_xfer && m_left == 1));
            m_accept  = sample_valid && (!m_pend_full || m_promote);
            if (m_xfer) begin
                void'(exp_q.pop_front());
                m_left--;
            end
            if (m_promote) begin
                exp_q.push_back({8'hA5, m_seq});
                for (int k = 0; k < NUM_CH; k++) exp_q.push_back(chan_word(m_pend[k*DATA_W +: DATA_W]));
                m_left = NUM_CH + 1;
                m_seq  = m_seq + 8'd1;
            end
            if (m_accept) begin
                m_pend      = samples;
                m_pend_full = 1'b1;
            end else if (m_promote) begin
                m_pend_full = 1'b0;
            end
            if (sample_valid && !m_accept && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(if1.out_valid), 32'(m_left > 0));
            if (m_left > 0 && exp_q.size() > 0) check("out_data", 32'(if1.out_data), 32'(exp_q[0]));
            check("busy", 32'(busy), 32'(m_pend_full || m_left > 0));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("seq", 32'(seq), 32'(m_seq));
        end
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0:       if1.out_ready = rdy_const;
            1: begin if1.out_ready = (pat_i % 3 == 0); pat_i++; end
            default: if1.out_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [FW-1:0] s);
        @(negedge clk);
        samples = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("word_count_reached", 32'(got_q.size() >= n), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [FW-1:0] sx;
        reset = 1'b1;
        sample_valid = 1'b0;
        samples = '0;

        // single frame, ready held high
        rdy_mode = 0; rdy_const = 1'b1;
        do_reset();
        chk_en = 1'b1;
        check("reset_out_valid", 32'(if1.out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop", 32'(drop_cnt), 32'd0);
        check("reset_seq", 32'(seq), 32'd0);
        strobe(ramp(14'h0100));
        wait_words(9, 40);
        check("t1_hdr", 32'(got_q[0]), 32'h0000A500);
        check("t1_ch0", 32'(got_q[1]), 32'h00000100);
        check("t1_ch7", 32'(got_q[8]), 32'h00000107);
        check("t1_consecutive", 32'(got_t[8] - got_t[0]), 32'd8);
        repeat (2) @(negedge clk);
        check("t1_valid_drop", 32'(if1.out_valid), 32'd0);
        check("t1_seq", 32'(seq), 32'd1);

        // backpressure 1,0,0 pattern
        do_reset();
        rdy_mode = 1;
        strobe(ramp(14'h0100));
        wait_words(9, 80);
        check("t2_hdr", 32'(got_q[0]), 32'h0000A500);
        check("t2_ch3", 32'(got_q[4]), 32'h00000103);
        repeat (4) @(negedge clk);
        check("t2_no_extra", 32'(got_q.size()), 32'd9);

        // overflow: one frame in flight, one pending, third dropped
        rdy_mode = 0; rdy_const = 1'b0;
        do_reset();
        @(negedge clk);
        strobe(ramp(14'h0200));
        strobe(ramp(14'h0300));
        strobe(ramp(14'h0400));
        check("t3_drop", 32'(drop_cnt), 32'd1);
        check("t3_drop_w2", 32'(drop_cnt2), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        rdy_const = 1'b1;
        wait_words(18, 80);
        check("t3_hdr0", 32'(got_q[0]), 32'h0000A500);
        check("t3_hdr1", 32'(got_q[9]), 32'h0000A501);
        check("t3_f2_ch0", 32'(got_q[10]), 32'h00000300);
        check("t3_back2back", 32'(got_t[17] - got_t[0]), 32'd17);

        // reset after three channel words, from a state with seq=2, drop=1
        base = got_q.size();
        strobe(rand_frame());
        wait_words(base + 4, 40);
        reset = 1'b1;
        @(negedge clk);
        check("t5_valid", 32'(if1.out_valid), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        check("t5_seq", 32'(seq), 32'd0);
        reset = 1'b0;
        strobe(rand_frame());
        wait_words(9, 40);
        check("t5_hdr", 32'(got_q[0]), 32'h0000A500);

        // extension of channel words
        do_reset();
        sx = '0;
        sx[DATA_W-1:0] = 14'h2001;
        strobe(sx);
        wait_words(9, 40);
`ifdef OCTAL_SER_SIGN_EXT_EN
        check("t4_ext", 32'(got_q[1]), 32'h0000E001);
`else
        check("t4_ext", 32'(got_q[1]), 32'h00002001);
`endif

        // randomized traffic and backpressure
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            samples = rand_frame();
            sample_valid = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        rdy_mode = 0; rdy_const = 1'b1;
        repeat (30) @(negedge clk);

        // 257 frames at the sustained rate: header byte wraps, nothing dropped
        do_reset();
        for (int f = 0; f < 257; f++) begin
            strobe(rand_frame());
            repeat (7) @(negedge clk);
        end
        wait_words(257 * 9, 100);
        check("t7_hdr_ff", 32'(got_q[255*9]), 32'h0000A5FF);
        check("t7_hdr_wrap", 32'(got_q[256*9]), 32'h0000A500);
        check("t7_no_drop", 32'(drop_cnt), 32'd0);
        check("t7_sat", 32'(drop_cnt2), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
